// File: rtl/fma16_arb.sv
// Round-robin arbiter and two-stage pipeline controller for one shared fma16 datapath.
// Optional sticky exception flags are built only when FMA16_ARB_STICKY_EN is defined.
module fma16_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_x,
  input  logic [15:0] req0_y,
  input  logic [15:0] req0_z,
  input  logic [5:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_x,
  input  logic [15:0] req1_y,
  input  logic [15:0] req1_z,
  input  logic [5:0]  req1_ctrl,
  output logic [15:0] fma_x,
  output logic [15:0] fma_y,
  output logic [15:0] fma_z,
  output logic [1:0]  fma_roundmode,
  output logic        fma_mul,
  output logic        fma_add,
  output logic        fma_negp,
  output logic        fma_negz,
  input  logic [15:0] fma_result,
  input  logic [3:0]  fma_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags,
  input  logic        flags_clr,
  output logic [3:0]  sticky_flags
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 6;
  localparam int unsigned FW = 4;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] z;
    logic [CW-1:0] ctrl;
  } bundle_t;

  logic          s1_v_q, s1_v_d;
  bundle_t       s1_q, s1_d;
  logic          s1_id_q, s1_id_d;
  logic          r_v_q, r_v_d;
  logic [DW-1:0] r_result_q, r_result_d;
  logic [FW-1:0] r_flags_q, r_flags_d;
  logic          r_id_q, r_id_d;
  logic          last_q, last_d;

  logic adv, load, gnt0, gnt1, rsp_hs;

  // Pipeline handshake: S1 drains into R whenever R is free or being consumed.
  assign adv    = s1_v_q & (~r_v_q | rsp_ready);
  assign load   = ~s1_v_q | adv;
  assign rsp_hs = r_v_q & rsp_ready;

  // Round-robin: on contention the requester that did not win last time goes first.
  assign gnt0 = req0_valid & (~req1_valid | last_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_q);

  assign req0_ready = reset & load & gnt0;
  assign req1_ready = reset & load & gnt1;

  always_comb begin
    s1_v_d     = s1_v_q;
    s1_d       = s1_q;
    s1_id_d    = s1_id_q;
    last_d     = last_q;
    r_v_d      = r_v_q;
    r_result_d = r_result_q;
    r_flags_d  = r_flags_q;
    r_id_d     = r_id_q;

    if (load) begin
      if (gnt0 | gnt1) begin
        s1_v_d  = 1'b1;
        s1_id_d = gnt1;
        last_d  = gnt1;
        s1_d    = gnt1 ? bundle_t'{req1_x, req1_y, req1_z, req1_ctrl}
                       : bundle_t'{req0_x, req0_y, req0_z, req0_ctrl};
      end else begin
        s1_v_d = 1'b0;
      end
    end

    if (adv) begin
      r_v_d      = 1'b1;
      r_result_d = fma_result;
      r_flags_d  = fma_flags;
      r_id_d     = s1_id_q;
    end else if (rsp_hs) begin
      r_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v_q     <= 1'b0;
      s1_q       <= '0;
      s1_id_q    <= 1'b0;
      last_q     <= 1'b1;
      r_v_q      <= 1'b0;
      r_result_q <= '0;
      r_flags_q  <= '0;
      r_id_q     <= 1'b0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_q       <= s1_d;
      s1_id_q    <= s1_id_d;
      last_q     <= last_d;
      r_v_q      <= r_v_d;
      r_result_q <= r_result_d;
      r_flags_q  <= r_flags_d;
      r_id_q     <= r_id_d;
    end
  end

  assign fma_x         = s1_q.x;
  assign fma_y         = s1_q.y;
  assign fma_z         = s1_q.z;
  assign fma_roundmode = s1_q.ctrl[5:4];
  assign fma_mul       = s1_q.ctrl[3];
  assign fma_add       = s1_q.ctrl[2];
  assign fma_negp      = s1_q.ctrl[1];
  assign fma_negz      = s1_q.ctrl[0];

  assign rsp_valid  = r_v_q;
  assign rsp_id     = r_id_q;
  assign rsp_result = r_result_q;
  assign rsp_flags  = r_flags_q;

`ifdef FMA16_ARB_STICKY_EN
  logic [FW-1:0] sticky_q, sticky_d;

  // Flags consumed in the same cycle as a clear survive it.
  always_comb begin
    sticky_d = (flags_clr ? FW'(0) : sticky_q) | (rsp_hs ? r_flags_q : FW'(0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sticky_q <= '0;
    else        sticky_q <= sticky_d;
  end

  assign sticky_flags = sticky_q;
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign sticky_flags     = '0;
`endif

endmodule
